// File: rtl/drink_pkg.sv
// Shared definitions for the two-slot drink front end.
//   - coin encodings and their value in half-yuan units
//   - slot FSM state type (IDLE / WAIT / VEND)
//   - arbiter FSM state type (A_IDLE / A_START / A_WAIT)
package drink_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        VEND = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_START = 2'd1,
        A_WAIT  = 2'd2
    } arb_state_t;

    // Value of a coin code in half-yuan units; the invalid code is worth nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] coin);
        logic [1:0] units;
        case (coin)
            COIN_HALF:          units = 2'd1;
            COIN_ONE:           units = 2'd2;
            COIN_NONE, COIN_BAD: units = 2'd0;
            default:            units = 2'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/drink_slot.sv
// One coin slot: credit accumulation, request to the arbiter, vend completion
// and change/refund generation.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   coin, cancel     coin code and refund request from the slot hardware
//   grant            arbiter accepts this slot's request (combinational, A_IDLE)
//   done             dispenser finished for this slot (combinational, A_WAIT)
//   req              slot is waiting for the dispenser
//   drink            registered one-cycle drink pulse
//   back             registered change/refund, nonzero for one cycle only
//   coin_rej         registered one-cycle pulse: coin ignored while busy
//
// state | meaning
// IDLE  | accepting coins, credit below PRICE
// WAIT  | credit reached PRICE, requesting the dispenser
// VEND  | dispenser running for this slot, waiting for done
module drink_slot
    import drink_pkg::*;
#(
    parameter int PRICE = 3,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          grant,
    input  logic          done,
    output logic          req,
    output logic          drink,
    output logic [CW-1:0] back,
    output logic          coin_rej
);

    slot_state_t   state, state_nxt;
    logic [CW-1:0] credit, credit_nxt;
    logic [CW-1:0] coin_val;
    logic [CW-1:0] sum;
    logic          drink_nxt;
    logic [CW-1:0] back_nxt;
    logic          rej_nxt;

    assign req = (state == WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            credit   <= '0;
            drink    <= 1'b0;
            back     <= '0;
            coin_rej <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            drink    <= drink_nxt;
            back     <= back_nxt;
            coin_rej <= rej_nxt;
        end
    end

    always_comb begin
        coin_val   = CW'(coin_units(coin));
        sum        = credit + coin_val;
        state_nxt  = state;
        credit_nxt = credit;
        drink_nxt  = 1'b0;
        back_nxt   = '0;
        rej_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // Cancel wins over a same-cycle coin; the coin goes straight back.
                if (cancel) begin
                    back_nxt   = sum;
                    credit_nxt = '0;
                end else if (coin_val != '0) begin
                    credit_nxt = sum;
                    if (sum >= CW'(PRICE))
                        state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cancel) begin
                    back_nxt   = sum;
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    rej_nxt = (coin_val != '0);
                    if (grant)
                        state_nxt = VEND;
                end
            end
            VEND: begin
                rej_nxt = (coin_val != '0);
                if (done) begin
                    drink_nxt  = 1'b1;
                    back_nxt   = credit - CW'(PRICE);
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase
    end

endmodule

// File: rtl/drink_arbiter.sv
// Two-slot drink front end: two drink_slot instances share one dispenser
// through a round-robin arbiter and a start/done handshake.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   coin0/1, cancel0/1    slot inputs
//   disp_done             dispenser finished (one-cycle pulse)
//   disp_start            registered one-cycle dispenser start pulse
//   disp_sel              slot being served, held from start until done
//   drink0/1, back0/1     per-slot drink pulse and change/refund
//   coin_rej0/1           per-slot coin-ignored pulse
//
// state   | meaning
// A_IDLE  | dispenser free, choosing a waiting slot
// A_START | slot granted, issuing disp_start
// A_WAIT  | dispenser running, waiting for disp_done
module drink_arbiter
    import drink_pkg::*;
#(
    parameter int PRICE = 3,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    coin0,
    input  logic [1:0]    coin1,
    input  logic          cancel0,
    input  logic          cancel1,
    input  logic          disp_done,
    output logic          disp_start,
    output logic          disp_sel,
    output logic          drink0,
    output logic          drink1,
    output logic [CW-1:0] back0,
    output logic [CW-1:0] back1,
    output logic          coin_rej0,
    output logic          coin_rej1
);

    arb_state_t state, state_nxt;
    logic       ptr, ptr_nxt;
    logic       sel_nxt;
    logic       start_nxt;
    logic       req0, req1;
    logic       grant0, grant1;
    logic       done0, done1;
    logic       win;
    logic       win_cancel;

    drink_slot #(.PRICE(PRICE), .CW(CW)) u_slot0 (
        .clk      (clk),
        .reset    (reset),
        .coin     (coin0),
        .cancel   (cancel0),
        .grant    (grant0),
        .done     (done0),
        .req      (req0),
        .drink    (drink0),
        .back     (back0),
        .coin_rej (coin_rej0)
    );

    drink_slot #(.PRICE(PRICE), .CW(CW)) u_slot1 (
        .clk      (clk),
        .reset    (reset),
        .coin     (coin1),
        .cancel   (cancel1),
        .grant    (grant1),
        .done     (done1),
        .req      (req1),
        .drink    (drink1),
        .back     (back1),
        .coin_rej (coin_rej1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= A_IDLE;
            ptr        <= 1'b0;
            disp_sel   <= 1'b0;
            disp_start <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            disp_sel   <= sel_nxt;
            disp_start <= start_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        sel_nxt    = disp_sel;
        start_nxt  = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        win        = (req0 && req1) ? ptr : req1;
        win_cancel = win ? cancel1 : cancel0;
        case (state)
            A_IDLE: begin
                // A cancel from the chosen slot drops the grant entirely; the
                // other slot is picked up on a later cycle.
                if ((req0 || req1) && !win_cancel) begin
                    grant0    = !win;
                    grant1    = win;
                    sel_nxt   = win;
                    ptr_nxt   = !win;
                    state_nxt = A_START;
                end
            end
            A_START: begin
                start_nxt = 1'b1;
                state_nxt = A_WAIT;
            end
            A_WAIT: begin
                if (disp_done) begin
                    done0     = !disp_sel;
                    done1     = disp_sel;
                    state_nxt = A_IDLE;
                end
            end
            default: state_nxt = A_IDLE;
        endcase
    end

endmodule

// File: tb/tb_drink_arbiter.sv
module tb_drink_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] coin0, coin1;
    logic       cancel0, cancel1;
    logic       disp_done;
    logic       disp_start, disp_sel;
    logic       drink0, drink1;
    logic [2:0] back0, back1;
    logic       coin_rej0, coin_rej1;

    drink_arbiter #(.PRICE(3), .CW(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .coin0      (coin0),
        .coin1      (coin1),
        .cancel0    (cancel0),
        .cancel1    (cancel1),
        .disp_done  (disp_done),
        .disp_start (disp_start),
        .disp_sel   (disp_sel),
        .drink0     (drink0),
        .drink1     (drink1),
        .back0      (back0),
        .back1      (back1),
        .coin_rej0  (coin_rej0),
        .coin_rej1  (coin_rej1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // expected outputs packed as {disp_start, disp_sel, drink0, drink1, back0, back1, coin_rej0, coin_rej1}
    typedef struct {
        logic        rst;
        logic [1:0]  c0;
        logic [1:0]  c1;
        logic        k0;
        logic        k1;
        logic        dd;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [11:0] o(input logic ds, input logic sel, input logic d0, input logic d1,
                                      input logic [2:0] b0, input logic [2:0] b1,
                                      input logic r0, input logic r1);
        return {ds, sel, d0, d1, b0, b1, r0, r1};
    endfunction

    task automatic add(input logic rst, input logic [1:0] c0, input logic [1:0] c1,
                       input logic k0, input logic k1, input logic dd, input logic [11:0] exp);
        vec_t v;
        v.rst = rst; v.c0 = c0; v.c1 = c1; v.k0 = k0; v.k1 = k1; v.dd = dd; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [1:0] c0, input logic [1:0] c1,
                         input logic k0, input logic k1, input logic dd);
        reset = rst; coin0 = c0; coin1 = c1; cancel0 = k0; cancel1 = k1; disp_done = dd;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {disp_start, disp_sel, drink0, drink1, back0, back1, coin_rej0, coin_rej1};
    endfunction

    localparam logic [1:0] N = 2'b00, H = 2'b01, Y = 2'b10, B = 2'b11;

    initial begin
        int cnt;
        drive(1'b1, N, N, 1'b0, 1'b0, 1'b0);

        // basic vend, exact price, done 4 cycles after start
        add(1, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 0 reset
        add(0, Y, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 1 credit 2
        add(0, H, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 2 credit 3 -> WAIT
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 3 grant slot0
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 4 disp_start
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 5
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 6
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 7
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 8
        add(0, N, N, 0, 0, 1, o(0, 0, 1, 0, 0, 0, 0, 0));   // 9 done -> drink0, back 0
        add(0, H, N, 1, 0, 0, o(0, 0, 0, 0, 1, 0, 0, 0));   // 10 cancel+half: credit was 0
        // overpay by one unit
        add(0, Y, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 11 credit 2
        add(0, Y, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 12 credit 4 -> WAIT
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 13 grant
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 14 start
        add(0, N, N, 0, 0, 1, o(0, 0, 1, 0, 1, 0, 0, 0));   // 15 done during start cycle
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 16
        // slot1 cancel with a coin on the same cycle
        add(0, N, H, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 17 credit1 1
        add(0, N, Y, 0, 1, 0, o(0, 0, 0, 0, 0, 3, 0, 0));   // 18 refund 3
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 19 no start
        // simultaneous contention after reset: slot0 then slot1
        add(1, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 20 reset
        add(0, Y, Y, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 21
        add(0, H, H, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 22 both WAIT
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 23 grant slot0
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 24
        add(0, N, N, 0, 0, 1, o(0, 0, 1, 0, 0, 0, 0, 0));   // 25
        add(0, N, N, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 26 grant slot1
        add(0, N, N, 0, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0));   // 27
        add(0, N, N, 0, 0, 1, o(0, 1, 0, 1, 0, 0, 0, 0));   // 28 drink1
        add(0, N, N, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 29
        // second contention: pointer back at slot0
        add(0, Y, Y, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 30
        add(0, H, H, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 31
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 32 grant slot0
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 33
        // coin + cancel while slot0 vends; coin on slot1 while it waits
        add(0, Y, N, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0));   // 34 rej0
        add(0, N, H, 0, 0, 1, o(0, 0, 1, 0, 0, 0, 0, 1));   // 35 drink0 back0 0, rej1
        add(0, N, N, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 36 grant slot1
        add(0, N, N, 0, 0, 0, o(1, 1, 0, 0, 0, 0, 0, 0));   // 37
        add(0, N, N, 0, 0, 1, o(0, 1, 0, 1, 0, 0, 0, 0));   // 38 credit1 was 3
        // reset in A_WAIT, late done ignored, then normal vend
        add(0, Y, N, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 39
        add(0, H, N, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0));   // 40
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 41
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 42
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 43 A_WAIT
        add(1, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 44 reset
        add(0, N, N, 0, 0, 1, o(0, 0, 0, 0, 0, 0, 0, 0));   // 45 stale done ignored
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 46
        add(0, Y, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 47
        add(0, Y, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 48 credit 4
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 49
        add(0, N, N, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0));   // 50
        add(0, N, N, 0, 0, 1, o(0, 0, 1, 0, 1, 0, 0, 0));   // 51
        // invalid coin not credited, not flagged
        add(0, B, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 52
        add(0, N, N, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 53 refund of 0 -> no pulse
        // cancel on the grant cycle suppresses the grant
        add(0, N, Y, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 54
        add(0, N, H, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 55 slot1 WAIT
        add(0, N, N, 0, 1, 0, o(0, 0, 0, 0, 0, 3, 0, 0));   // 56 cancel in WAIT
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 57
        add(0, N, N, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0));   // 58 no start

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].c0, vecs[i].c1, vecs[i].k0, vecs[i].k1, vecs[i].dd);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // WAIT-to-start latency, disp_sel held through a long vend, done outside A_WAIT
        @(negedge clk);
        drive(1'b0, N, Y, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        coin1 = H;
        @(posedge clk);
        @(negedge clk);
        coin1 = N;
        cnt = 1;
        while (cnt < 8 && !disp_start) begin
            @(posedge clk);
            #1;
            if (!disp_start) cnt++;
        end
        check("start_latency", 12'(cnt), 12'd2);
        check("start_sel", {11'd0, disp_sel}, 12'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", i), outs(), o(0, 1, 0, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        disp_done = 1'b1;
        @(posedge clk);
        #1;
        check("long_done", outs(), o(0, 1, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        disp_done = 1'b1;
        @(posedge clk);
        #1;
        check("idle_done", outs(), o(0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        disp_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
